// File: rtl/dual_rail_pkg.sv
// dual_rail_pkg: shared state type, rail-pair codes and bit encoder for the dual-rail RZ link
//   state_e  : transmitter FSM states
//   SPACER/ONE/ZERO : (t,f) rail-pair codes
//   encode() : maps one data bit to its (t,f) pair
package dual_rail_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_NACK} state_e;
  localparam logic [1:0] SPACER = 2'b00;
  localparam logic [1:0] ONE    = 2'b10;
  localparam logic [1:0] ZERO   = 2'b01;
  function automatic logic [1:0] encode(input logic b);
    return b ? ONE : ZERO;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, async active-low reset to 0
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/dual_rail_tx.sv
// dual_rail_tx: single-rail valid/ready in, dual-rail return-to-zero codewords out, four-phase ack paced
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/valid/ready  : word input handshake
//   rail_t, rail_f       : true / complement rails, (0,0) spacer between codewords
//   ack_in               : receiver completion, asynchronous
//   busy                 : transfer in progress
//   timeout_err, err_clr : sticky acknowledge-timeout flag and its clear
module dual_rail_tx
  import dual_rail_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SPACER_MIN  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] rail_t,
  output logic [WIDTH-1:0] rail_f,
  input  logic             ack_in,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);
  localparam int SW = $clog2(SPACER_MIN + 2);
  localparam int TW = $clog2(ACK_TIMEOUT + 2);
  state_e           state_q;
  logic [WIDTH-1:0] rail_t_q, rail_f_q, enc_t, enc_f;
  logic [SW-1:0]    sp_cnt_q;
  logic [TW-1:0]    tmo_cnt_q;
  logic             err_q, ack_s, tmo_hit, tmo_fire;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d_i(ack_in), .q_o(ack_s));
  always_comb begin
    enc_t = '0;
    enc_f = '0;
    for (int i = 0; i < WIDTH; i++) {enc_t[i], enc_f[i]} = encode(in_data[i]);
  end
  assign in_ready = state_q == IDLE && sp_cnt_q >= SW'(SPACER_MIN) && !ack_s;
  // the counter is cleared on phase entry, so ACK_TIMEOUT-1 seen here means this edge is the ACK_TIMEOUT-th
  assign tmo_hit  = tmo_cnt_q == TW'(ACK_TIMEOUT - 1);
  assign tmo_fire = tmo_hit && ((state_q == WAIT_ACK && !ack_s) || (state_q == WAIT_NACK && ack_s));
  // rails are loaded pairwise from encode() or cleared together, so (1,1) can never be registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rail_t_q  <= '0;
      rail_f_q  <= '0;
      sp_cnt_q  <= SW'(SPACER_MIN);
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      sp_cnt_q  <= state_q == WAIT_ACK ? '0 : sp_cnt_q + SW'(sp_cnt_q < SW'(SPACER_MIN));
      tmo_cnt_q <= tmo_cnt_q + TW'(tmo_cnt_q < TW'(ACK_TIMEOUT));
      err_q     <= tmo_fire || (err_q && !err_clr);
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          state_q   <= WAIT_ACK;
          rail_t_q  <= enc_t;
          rail_f_q  <= enc_f;
          tmo_cnt_q <= '0;
        end
        WAIT_ACK: if (ack_s || tmo_hit) begin
          state_q   <= WAIT_NACK;
          rail_t_q  <= '0;
          rail_f_q  <= '0;
          tmo_cnt_q <= '0;
        end
        WAIT_NACK: if (!ack_s || tmo_hit) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rail_t      = rail_t_q;
  assign rail_f      = rail_f_q;
  assign busy        = state_q != IDLE;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_dual_rail_tx.sv
// tb_dual_rail_tx: directed and randomized checks of dual_rail_tx against a timestamp-based reference model
module tb_dual_rail_tx;
  localparam int W = 4, SPM = 2, ATO = 15;
  logic clk = 0, rst_n = 1, in_valid = 0, ack_in = 0, err_clr = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, busy, timeout_err;
  logic [W-1:0] rail_t, rail_f;
  int checks = 0, failures = 0;
  dual_rail_tx #(.WIDTH(W), .SPACER_MIN(SPM), .ACK_TIMEOUT(ATO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rail_t(rail_t), .rail_f(rail_f), .ack_in(ack_in), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // reference model: phase (0 idle, 1 codeword out, 2 spacer awaiting ack release) plus edge timestamps
  int cyc = 0, ph = 0, t_ent = 0, t_sp = -SPM, acc_cnt = 0;
  bit s1 = 0, s2 = 0, m_err = 0, m_rdy = 1, m_set = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] acc_q[$];
  int acc_cyc[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; s1 = 0; s2 = 0; m_err = 0; t_sp = cyc - SPM; m_rdy = 1;
    end else begin
      m_set = 0;
      cyc++;
      if (ph == 0) begin
        if (in_valid && m_rdy) begin
          ph = 1; m_word = in_data; t_ent = cyc; acc_cnt++;
          acc_q.push_back(in_data); acc_cyc.push_back(cyc);
        end
      end else if (ph == 1) begin
        if (s2 || cyc - t_ent == ATO) begin m_set = !s2; ph = 2; t_ent = cyc; t_sp = cyc; end
      end else if (!s2) ph = 0;
      else if (cyc - t_ent == ATO) begin m_set = 1; ph = 0; end
      m_err = m_set || (m_err && !err_clr);
      s2 = s1; s1 = ack_in;
      m_rdy = ph == 0 && cyc - t_sp >= SPM && !s2;
    end
  end
  int run = 0;
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_rdy);
    chk("busy", busy, ph != 0);
    chk("timeout_err", timeout_err, m_err);
    chk("rail_t", rail_t, ph == 1 ? m_word : '0);
    chk("rail_f", rail_f, ph == 1 ? (m_word ^ 4'hF) : '0);
    chk("no_one_one", rail_t & rail_f, 0);
    if ((rail_t | rail_f) != 0) begin
      if (run > 0) chk("spacer_len_ok", run >= SPM, 1);
      run = 0;
    end else run++;
  end
  // receiver stand-in: four-phase completion detector with programmable response latency
  bit auto_ack = 0, rand_lat = 0;
  int lat = 0, rcnt = 0;
  logic [W-1:0] rx_q[$];
  task automatic tick();
    logic want;
    @(posedge clk); #1;
    if (auto_ack) begin
      want = (rail_t ^ rail_f) == {W{1'b1}} ? 1'b1 : (rail_t | rail_f) == 0 ? 1'b0 : ack_in;
      if (want != ack_in) begin
        if (rcnt >= lat) begin
          ack_in = want; rcnt = 0;
          if (want) rx_q.push_back(rail_t);
        end else rcnt++;
      end else begin
        rcnt = 0;
        if (rand_lat) lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      end
    end
  endtask
  task automatic send(input logic [W-1:0] w);
    int c0;
    c0 = acc_cnt;
    in_data = w; in_valid = 1;
    for (int i = 0; i < 100 && acc_cnt == c0; i++) tick();
    chk("accept_in_time", acc_cnt != c0, 1);
    in_valid = 0; in_data = W'($urandom);
  endtask
  task automatic idle_wait();
    for (int i = 0; i < 300 && !(ph == 0 && m_rdy && !ack_in); i++) tick();
    chk("idle_reached", ph == 0 && m_rdy && !ack_in, 1);
  endtask
  initial begin
    logic [W-1:0] exp_b2b [3];
    exp_b2b = '{4'hF, 4'h0, 4'h6};
    #1 rst_n = 0;
    tick(); tick();
    chk("rst_ready", in_ready, 1); chk("rst_rail_t", rail_t, 0); chk("rst_rail_f", rail_f, 0);
    chk("rst_busy", busy, 0); chk("rst_err", timeout_err, 0);
    rst_n = 1;
    tick();
    send(4'b1010);
    chk("t1_rail_t", rail_t, 4'b1010); chk("t1_rail_f", rail_f, 4'b0101); chk("t1_ready_low", in_ready, 0);
    tick(); ack_in = 1;
    tick(); tick();
    chk("t1_hold", rail_t, 4'b1010);
    tick();
    chk("t1_spacer_t", rail_t, 0); chk("t1_spacer_f", rail_f, 0); chk("t1_busy", busy, 1);
    ack_in = 0;
    tick(); tick();
    chk("t1_ready_wait", in_ready, 0);
    tick();
    chk("t1_ready_back", in_ready, 1); chk("t1_idle", busy, 0);
    auto_ack = 1; lat = 0; acc_q.delete(); acc_cyc.delete(); rx_q.delete();
    in_valid = 1; in_data = 4'hF;
    for (int i = 0; i < 100 && acc_q.size() < 3; i++) begin
      tick();
      in_data = acc_q.size() == 0 ? 4'hF : acc_q.size() == 1 ? 4'h0 : 4'h6;
    end
    in_valid = 0;
    idle_wait();
    chk("b2b_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("b2b_word", i < rx_q.size() ? 32'(rx_q[i]) : 32'hDEAD, 32'(exp_b2b[i]));
    if (acc_cyc.size() >= 2) chk("b2b_period", acc_cyc[1] - acc_cyc[0], 7);
    auto_ack = 0;
    send(4'h3);
    repeat (13) tick();
    tick();
    chk("to_not_yet", timeout_err, 0); chk("to_busy", busy, 1); chk("to_word", rail_t, 4'h3);
    err_clr = 1;
    tick();
    chk("to_set_wins", timeout_err, 1); chk("to_spacer_t", rail_t, 0); chk("to_spacer_f", rail_f, 0);
    err_clr = 0;
    tick();
    chk("to_idle", busy, 0);
    err_clr = 1;
    tick();
    chk("to_cleared", timeout_err, 0);
    err_clr = 0;
    idle_wait();
    ack_in = 1;
    repeat (3) tick();
    in_data = 4'h5; in_valid = 1;
    repeat (4) begin
      tick();
      chk("stale_ready", in_ready, 0); chk("stale_rails", rail_t | rail_f, 0); chk("stale_busy", busy, 0);
    end
    ack_in = 0;
    send(4'h5);
    chk("stale_word", rail_t, 4'h5);
    auto_ack = 1;
    idle_wait();
    auto_ack = 0;
    send(4'h9);
    tick();
    chk("rst_mid_word", rail_t, 4'h9); chk("rst_mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("async_rail_t", rail_t, 0); chk("async_rail_f", rail_f, 0); chk("async_busy", busy, 0);
    tick(); tick();
    rst_n = 1;
    auto_ack = 1; rx_q.delete();
    send(4'hC);
    idle_wait();
    chk("post_rst_rx", rx_q.size() == 1 ? 32'(rx_q[0]) : 32'hDEAD, 32'hC);
    rand_lat = 1;
    repeat (800) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      err_clr = $urandom_range(0, 15) == 0;
      tick();
    end
    in_valid = 0; err_clr = 0; rand_lat = 0; lat = 0;
    idle_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
